// File: rtl/ppa_pkg.sv
// Shared types and helpers for the pipelined prefix adder.
// Sizes the pipeline: prefix levels and segment count.
package ppa_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int nseg(input int width, input int lps);
        return (levels(width) + lps - 1) / lps;
    endfunction

    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage

// File: rtl/ppa_prefix_level.sv
// One combinational Kogge-Stone level: bit i merges with bit i-DIST.
// Bits below DIST pass through unchanged.
module ppa_prefix_level
    import ppa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] g_out
);

    // Merge each bit with its DIST-away lower neighbour
    always_comb begin
        pg_t r;
        r = '0;
        p_out = p_in;
        g_out = g_in;
        for (int i = DIST; i < WIDTH; i++) begin
            r = pg_combine('{p: p_in[i], g: g_in[i]},
                           '{p: p_in[i-DIST], g: g_in[i-DIST]});
            p_out[i] = r.p;
            g_out[i] = r.g;
        end
    end

endmodule

// File: rtl/ppa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Define PPA_SAT_EN to enable signed saturation on overflow.
module ppa_pipe_adder
    import ppa_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_sat,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L    = levels(WIDTH);
    localparam int LPS  = LEVELS_PER_STAGE;
    localparam int NSEG = nseg(WIDTH, LEVELS_PER_STAGE);
    localparam int MSB  = WIDTH - 1;

    logic             stall;
    logic [WIDTH-1:0] bx;

    logic [NSEG-1:0]  seg_v;
    logic [WIDTH-1:0] seg_p     [NSEG];
    logic [WIDTH-1:0] seg_g     [NSEG];
    logic [WIDTH-1:0] seg_h     [NSEG];
    logic [WIDTH-1:0] nxt_p     [NSEG];
    logic [WIDTH-1:0] nxt_g     [NSEG];
    logic             seg_a_msb [NSEG];
    logic             seg_b_msb [NSEG];
    logic             seg_cin   [NSEG];
    op_t              seg_op    [NSEG];
    logic [TAG_W-1:0] seg_tag   [NSEG];
`ifdef PPA_SAT_EN
    logic             seg_sat   [NSEG];
`else
    logic             unused_sat;
    assign unused_sat = in_sat;
`endif

    logic [WIDTH-1:0] chain_p [1:L];
    logic [WIDTH-1:0] chain_g [1:L];

    logic             c0;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic             cout;
    logic             ovf;
    logic             a_msb;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign bx       = in_sub ? ~in_b : in_b;
    assign nxt_p[0] = in_a | bx;
    assign nxt_g[0] = in_a & bx;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        logic [WIDTH-1:0] pi;
        logic [WIDTH-1:0] gi;
        if (k % LPS == 0) begin : g_seg
            assign pi = seg_p[k/LPS];
            assign gi = seg_g[k/LPS];
        end else begin : g_chain
            assign pi = chain_p[k];
            assign gi = chain_g[k];
        end
        ppa_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_lvl (
            .p_in  (pi),
            .g_in  (gi),
            .p_out (chain_p[k+1]),
            .g_out (chain_g[k+1])
        );
    end

    for (genvar s = 1; s < NSEG; s++) begin : g_nxt
        assign nxt_p[s] = chain_p[s*LPS];
        assign nxt_g[s] = chain_g[s*LPS];
    end

    // Stage valid bits advance together unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_v <= '0;
        end else if (!stall) begin
            seg_v[0] <= in_valid;
            for (int s = 1; s < NSEG; s++) seg_v[s] <= seg_v[s-1];
        end
    end

    // Stage payloads: prefix state plus operation context
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int s = 0; s < NSEG; s++) begin
                seg_p[s] <= nxt_p[s];
                seg_g[s] <= nxt_g[s];
            end
            seg_h[0]     <= in_a ^ bx;
            seg_a_msb[0] <= in_a[MSB];
            seg_b_msb[0] <= bx[MSB];
            seg_cin[0]   <= in_cin;
            seg_op[0]    <= in_sub ? OP_SUB : OP_ADD;
            seg_tag[0]   <= in_tag;
`ifdef PPA_SAT_EN
            seg_sat[0]   <= in_sat;
`endif
            for (int s = 1; s < NSEG; s++) begin
                seg_h[s]     <= seg_h[s-1];
                seg_a_msb[s] <= seg_a_msb[s-1];
                seg_b_msb[s] <= seg_b_msb[s-1];
                seg_cin[s]   <= seg_cin[s-1];
                seg_op[s]    <= seg_op[s-1];
                seg_tag[s]   <= seg_tag[s-1];
`ifdef PPA_SAT_EN
                seg_sat[s]   <= seg_sat[s-1];
`endif
            end
        end
    end

    // Final segment: fold carry-in into prefix carries, form flags
    always_comb begin
        a_msb   = seg_a_msb[NSEG-1];
        c0      = (seg_op[NSEG-1] == OP_SUB) ? 1'b1 : seg_cin[NSEG-1];
        carry   = {chain_g[L][MSB-1:0]
                   | (chain_p[L][MSB-1:0] & {(WIDTH-1){c0}}), c0};
        sum_raw = seg_h[NSEG-1] ^ carry;
        cout    = chain_g[L][MSB] | (chain_p[L][MSB] & c0);
        ovf     = (a_msb == seg_b_msb[NSEG-1])
                  && (sum_raw[MSB] != a_msb);
        sum_fin = sum_raw;
`ifdef PPA_SAT_EN
        if (seg_sat[NSEG-1] && ovf)
            sum_fin = a_msb ? {1'b1, {MSB{1'b0}}}
                            : {1'b0, {MSB{1'b1}}};
`endif
    end

    // Output register holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= seg_v[NSEG-1];
            if (seg_v[NSEG-1]) begin
                out_sum  <= sum_fin;
                out_cout <= cout;
                out_ovf  <= ovf;
                out_zero <= ~|sum_fin;
                out_tag  <= seg_tag[NSEG-1];
            end
        end
    end

endmodule
